bus_arbiter32: RTL

- Round-robin arbiter and sequencer for a shared 32-bit bus. Each requester drives the bus through its own bufif32 tri-state buffer.
- Generates one-hot drive enables for the bufif32 C inputs, so at most one buffer drives per cycle.
- Inserts turnaround cycles between owners to prevent driver overlap.
- Caps bus tenure so no requester can starve the others.

---
 rtl/bus_arbiter32.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/bus_arbiter32.sv
// Round-robin arbiter for a shared 32-bit bus driven through per-requester bufif32 buffers.
// Grants are one-hot and registered, tenure is capped, and every release is followed by turnaround.
module bus_arbiter32 #(
  parameter int NREQ        = 4,
  parameter int OWNER_W     = 2,
  parameter int MAX_HOLD    = 4,
  parameter int TURN_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    drv_en,
  output logic [OWNER_W-1:0] owner,
  output logic               busy,
  output logic               turn
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [NREQ-1:0]      grant_q, grant_d;
  logic [NREQ-1:0]      drv_q;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [OWNER_W-1:0]   last_q, last_d;
  logic [7:0]           hold_q, hold_d;
  logic [3:0]           tcnt_q, tcnt_d;
  logic                 busy_q, busy_d;
  logic                 turn_q, turn_d;
  logic [OWNER_W-1:0]   win_s;
  logic [OWNER_W:0]     cand_s;
  logic                 rel_s;

  // Winner search: walk downward so the nearest requester after last_q is written last.
  always_comb begin
    win_s  = last_q;
    cand_s = '0;
    for (int i = NREQ; i >= 1; i--) begin
      cand_s = {1'b0, last_q} + (OWNER_W+1)'(i);
      if (cand_s >= (OWNER_W+1)'(NREQ)) begin
        cand_s = cand_s - (OWNER_W+1)'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      if (req[cand_s[OWNER_W-1:0]]) begin
        win_s = cand_s[OWNER_W-1:0];
      end else begin
        win_s = win_s;
      end
    end
  end

  assign rel_s = !req[owner_q] || ((MAX_HOLD != 0) && (hold_q == 8'(MAX_HOLD)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      drv_q   <= '0;
      owner_q <= '0;
      last_q  <= OWNER_W'(NREQ-1);
      hold_q  <= 8'd0;
      tcnt_q  <= 4'd0;
      busy_q  <= 1'b0;
      turn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      drv_q   <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      tcnt_q  <= tcnt_d;
      busy_q  <= busy_d;
      turn_q  <= turn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_GRANT;
          last_d  = win_s;
          hold_d  = 8'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (rel_s) begin
          state_d = ST_TURN;
          tcnt_d  = 4'd1;
        end else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end else begin
          hold_d = hold_q;
        end
      end
      ST_TURN: begin
        if (tcnt_q >= 4'(TURN_CYCLES)) begin
          state_d = ST_IDLE;
        end else begin
          tcnt_d = tcnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs follow the state being entered; a fresh grant comes from the IDLE winner.
  always_comb begin
    grant_d = '0;
    owner_d = owner_q;
    busy_d  = 1'b0;
    turn_d  = 1'b0;
    case (state_d)
      ST_GRANT: begin
        busy_d = 1'b1;
        if (state_q == ST_IDLE) begin
          grant_d = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
          owner_d = win_s;
        end else begin
          grant_d = grant_q;
        end
      end
      ST_TURN: turn_d = 1'b1;
      ST_IDLE: turn_d = 1'b0;
      default: grant_d = '0;
    endcase
  end

  assign grant  = grant_q;
  assign drv_en = drv_q;
  assign owner  = owner_q;
  assign busy   = busy_q;
  assign turn   = turn_q;

endmodule
